// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier (unsigned/signed) with valid/ready handshakes.
// Define MULT_ACC_EN to add the acc_en port and accumulate products into result.
module seq_mult_hs #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 2*IN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  a,
   input  logic [IN_WIDTH-1:0]  b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] result,
`ifdef MULT_ACC_EN
   input  logic                 acc_en,
`endif
   output logic                 busy
);

   localparam int CNT_W = $clog2(IN_WIDTH);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(IN_WIDTH-1);
   localparam logic [IN_WIDTH-1:0]  ZERO_IN  = '0;
   localparam logic [OUT_WIDTH-1:0] ZERO_OUT = '0;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [OUT_WIDTH-1:0]   p_q, sh_a_q, result_q;
   logic [IN_WIDTH-1:0]    mag_b_q;
   logic                   neg_q, out_valid_q, busy_q;

   logic [IN_WIDTH-1:0]    mag_a_d, mag_b_d;
   logic                   neg_d;
   logic [OUT_WIDTH-1:0]   p_add, prod, result_d;

`ifdef MULT_ACC_EN
   logic acc_q;
`endif

   // Magnitudes fit unsigned in IN_WIDTH bits, including |-2^(IN_WIDTH-1)|.
   always_comb begin
      mag_a_d  = (is_signed && a[IN_WIDTH-1]) ? (ZERO_IN - a) : a;
      mag_b_d  = (is_signed && b[IN_WIDTH-1]) ? (ZERO_IN - b) : b;
      neg_d    = is_signed && (a[IN_WIDTH-1] ^ b[IN_WIDTH-1]);
      p_add    = p_q + (mag_b_q[0] ? sh_a_q : ZERO_OUT);
      prod     = neg_q ? (ZERO_OUT - p_q) : p_q;
`ifdef MULT_ACC_EN
      result_d = acc_q ? (result_q + prod) : prod;
`else
      result_d = prod;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         p_q         <= '0;
         sh_a_q      <= '0;
         mag_b_q     <= '0;
         neg_q       <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef MULT_ACC_EN
         acc_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               sh_a_q  <= OUT_WIDTH'(mag_a_d);
               mag_b_q <= mag_b_d;
               neg_q   <= neg_d;
               p_q     <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
`ifdef MULT_ACC_EN
               acc_q   <= acc_en;
`endif
               state_q <= RUN;
            end
            RUN: begin
               p_q     <= p_add;
               sh_a_q  <= sh_a_q << 1;
               mag_b_q <= mag_b_q >> 1;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) state_q <= FIX;
            end
            FIX: begin
               result_q    <= result_d;
               out_valid_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

endmodule
